bram16_arbiter: RTL and testbench

//  Two-master round-robin arbiter/sequencer for one single-port 16-bit block RAM
//  (1-cycle registered read, read-before-write). Shares the RAM between the CPU

---
 rtl/bram16_arbiter.sv | 118 +++++++++++
 tb/tb_bram16_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram16_arbiter.sv
// bram16_arbiter: two-master round-robin sequencer for a single-port 16-bit
// block RAM with a 1-cycle registered read and read-before-write behaviour.
// Each access runs IDLE -> ISSUE -> CAPTURE -> DONE, so there is one access
// every four cycles, with a single-cycle ack back to the winning master.
module bram16_arbiter #(
  parameter int adr_width = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_adr,
  input  logic [15:0] i_dat_w,
  output logic [15:0] i_dat_r,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_adr,
  input  logic [15:0] d_dat_w,
  output logic [15:0] d_dat_r,
  output logic        d_ack,
  output logic [15:0] bram_a,
  output logic        bram_we,
  output logic [15:0] bram_wdata,
  input  logic [15:0] bram_rdata,
  output logic        busy,
  output logic        grant_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        take;
  logic        win_d;
  logic        win_we;
  logic [15:0] win_adr;
  logic [15:0] win_dat;

  // State register; reset aborts any access in flight.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Sequencing and arbitration: a tie goes to whoever did not own the last access.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    win_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          take      = 1'b1;
          win_d     = (i_req && d_req) ? !grant_d : d_req;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign win_we  = win_d ? d_we    : i_we;
  assign win_adr = win_d ? d_adr   : i_adr;
  assign win_dat = win_d ? d_dat_w : i_dat_w;
  assign busy    = (state != IDLE);

  // RAM pins, grant owner, read data and acks. Acks default low so they pulse
  // for exactly the DONE cycle; the loser's read data simply holds.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      bram_a     <= '0;
      bram_we    <= 1'b0;
      bram_wdata <= '0;
      grant_d    <= 1'b1;
      i_dat_r    <= '0;
      d_dat_r    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            bram_a     <= {win_adr[15:adr_width], win_adr[adr_width-1:0]};
            bram_we    <= win_we;
            bram_wdata <= win_dat;
            grant_d    <= win_d;
          end else begin
            bram_we <= 1'b0;
          end
        end
        ISSUE: bram_we <= 1'b0;
        CAPTURE: begin
          if (grant_d) begin
            d_dat_r <= bram_rdata;
            d_ack   <= 1'b1;
          end else begin
            i_dat_r <= bram_rdata;
            i_ack   <= 1'b1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram16_arbiter.sv
// Bench for bram16_arbiter: behavioural single-port RAM, expected-result
// scoreboard popped on every ack, and directed access sequences.
module tb_bram16_arbiter;

  logic        sys_clk;
  logic        sys_rst;
  logic        i_req, i_we, d_req, d_we;
  logic [15:0] i_adr, i_dat_w, d_adr, d_dat_w;
  logic [15:0] i_dat_r, d_dat_r;
  logic        i_ack, d_ack;
  logic [15:0] bram_a, bram_wdata, bram_rdata;
  logic        bram_we, busy, grant_d;

  typedef struct {
    bit          is_d;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] ram     [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [15:0] pre_val;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int we_cnt   = 0;
  int iack_cnt = 0;
  int dack_cnt = 0;
  int busy_lo  = 0;
  logic        prev_ack;
  logic [15:0] last_i, last_d;

  bram16_arbiter #(.adr_width(11)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .i_req(i_req), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w),
    .i_dat_r(i_dat_r), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_dat_w(d_dat_w),
    .d_dat_r(d_dat_r), .d_ack(d_ack),
    .bram_a(bram_a), .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .busy(busy), .grant_d(grant_d)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Single-port RAM: registered read of the old word, write at the same edge.
  always @(posedge sys_clk) begin
    bram_rdata <= ram[bram_a[10:1]];
    if (pre_en)       ram[pre_idx]      <= pre_val;
    else if (bram_we) ram[bram_a[10:1]] <= bram_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on ack, plus pulse/exclusivity/hold checks.
  always @(negedge sys_clk) begin
    exp_t e;
    if (bram_we) we_cnt++;
    if (!busy)   busy_lo++;
    if (i_ack)   iack_cnt++;
    if (d_ack)   dack_cnt++;
    if (!sys_rst) begin
      last_i = '0;
      last_d = '0;
    end else if (i_ack || d_ack) begin
      check_val("ack_both", {31'd0, i_ack & d_ack}, 32'd0);
      check_val("ack_pulse", {31'd0, prev_ack}, 32'd0);
      if (sb_q.size() == 0) begin
        check_val("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("ack_owner", {31'd0, d_ack}, {31'd0, e.is_d});
        check_val("grant_d", {31'd0, grant_d}, {31'd0, e.is_d});
        if (d_ack) begin
          check_val("d_dat_r", {16'd0, d_dat_r}, {16'd0, e.data});
          check_val("i_dat_r_hold", {16'd0, i_dat_r}, {16'd0, last_i});
          last_d = e.data;
        end else begin
          check_val("i_dat_r", {16'd0, i_dat_r}, {16'd0, e.data});
          check_val("d_dat_r_hold", {16'd0, d_dat_r}, {16'd0, last_d});
          last_i = e.data;
        end
      end
    end
    prev_ack = i_ack | d_ack;
  end

  task automatic preload(input logic [15:0] adr, input logic [15:0] val);
    @(negedge sys_clk);
    pre_en = 1'b1; pre_idx = adr[10:1]; pre_val = val;
    ref_mem[adr[10:1]] = val;
    @(negedge sys_clk);
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk); sys_rst = 1'b0;
    @(negedge sys_clk); sys_rst = 1'b1;
  endtask

  task automatic wait_any_ack(output int c);
    c = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (i_ack || d_ack) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) check_val("ack_timeout", 32'd1, 32'd0);
  endtask

  task automatic access(input bit is_d, input bit we, input logic [15:0] adr,
                        input logic [15:0] dat, input bit drop_early);
    int   start;
    bit   got;
    exp_t e;
    @(negedge sys_clk);
    if (is_d) begin d_req = 1'b1; d_we = we; d_adr = adr; d_dat_w = dat; end
    else      begin i_req = 1'b1; i_we = we; i_adr = adr; i_dat_w = dat; end
    start  = cyc;
    e.is_d = is_d;
    e.data = ref_mem[adr[10:1]];
    sb_q.push_back(e);
    if (we) ref_mem[adr[10:1]] = dat;
    @(negedge sys_clk);
    check_val("bram_a", {16'd0, bram_a}, {16'd0, adr});
    check_val("bram_we_issue", {31'd0, bram_we}, {31'd0, we});
    if (we) check_val("bram_wdata", {16'd0, bram_wdata}, {16'd0, dat});
    if (drop_early) begin i_req = 1'b0; d_req = 1'b0; end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if ((is_d && d_ack) || (!is_d && i_ack)) got = 1'b1;
      else @(negedge sys_clk);
    end
    check_val("ack_seen", {31'd0, got}, 32'd1);
    check_val("latency", cyc - start, 32'd3);
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    int c0, c1, c2, b0, we0, ia0, da0;
    sys_rst = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    i_req = 0; i_we = 0; i_adr = '0; i_dat_w = '0;
    d_req = 0; d_we = 0; d_adr = '0; d_dat_w = '0;
    prev_ack = 1'b0; last_i = '0; last_d = '0;
    repeat (2) @(negedge sys_clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_grant_d", {31'd0, grant_d}, 32'd1);
    check_val("rst_bram_we", {31'd0, bram_we}, 32'd0);
    check_val("rst_bram_a", {16'd0, bram_a}, 32'd0);
    check_val("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    check_val("rst_dat_r", {i_dat_r, d_dat_r}, 32'd0);
    preload(16'h0004, 16'hBEEF);
    preload(16'h0010, 16'h7777);
    preload(16'h0020, 16'hAAAA);
    preload(16'h0040, 16'h1111);
    preload(16'h0050, 16'h2222);
    @(negedge sys_clk); sys_rst = 1'b1;

    // Single I read
    we0 = we_cnt; ia0 = iack_cnt; da0 = dack_cnt;
    access(1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0);
    repeat (2) @(negedge sys_clk);
    check_val("t1_no_write", we_cnt - we0, 32'd0);
    check_val("t1_i_acks", iack_cnt - ia0, 32'd1);
    check_val("t1_d_acks", dack_cnt - da0, 32'd0);

    // D write then read back
    we0 = we_cnt;
    access(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0);
    repeat (2) @(negedge sys_clk);
    check_val("t2_we_cycles", we_cnt - we0, 32'd1);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

    // Contention after reset: I, D, I
    do_reset();
    @(negedge sys_clk);
    i_req = 1; i_we = 0; i_adr = 16'h0040;
    d_req = 1; d_we = 0; d_adr = 16'h0050;
    sb_q.push_back('{1'b0, 16'h1111});
    sb_q.push_back('{1'b1, 16'h2222});
    sb_q.push_back('{1'b0, 16'h1111});
    wait_any_ack(c0);
    wait_any_ack(c1);
    wait_any_ack(c2);
    i_req = 0; d_req = 0;
    check_val("t3_spacing1", c1 - c0, 32'd4);
    check_val("t3_spacing2", c2 - c1, 32'd4);

    // Back-to-back D reads with req held
    repeat (3) @(negedge sys_clk);
    d_req = 1; d_we = 0; d_adr = 16'h0050;
    for (int k = 0; k < 3; k++) sb_q.push_back('{1'b1, 16'h2222});
    wait_any_ack(c0);
    b0 = busy_lo;
    wait_any_ack(c1);
    wait_any_ack(c2);
    d_req = 0;
    check_val("t4_spacing1", c1 - c0, 32'd4);
    check_val("t4_spacing2", c2 - c1, 32'd4);
    check_val("t4_busy_low", busy_lo - b0, 32'd2);

    // Reset during ISSUE of a write: no write happens
    repeat (3) @(negedge sys_clk);
    d_req = 1; d_we = 1; d_adr = 16'h0020; d_dat_w = 16'h5555;
    @(negedge sys_clk);
    check_val("t5_in_issue", {31'd0, bram_we}, 32'd1);
    sys_rst = 1'b0; d_req = 0; d_we = 0;
    #1;
    check_val("t5_rst_we", {31'd0, bram_we}, 32'd0);
    check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
    check_val("t5_rst_grant", {31'd0, grant_d}, 32'd1);
    check_val("t5_rst_a", {bram_a, bram_wdata}, 32'd0);
    @(negedge sys_clk); sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

    // Request dropped right after being sampled
    ia0 = iack_cnt;
    access(1'b0, 1'b0, 16'h0004, 16'h0000, 1'b1);
    repeat (10) @(negedge sys_clk);
    check_val("t6_one_ack", iack_cnt - ia0, 32'd1);
    check_val("t6_idle", {31'd0, busy}, 32'd0);

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
